filter_stream: RTL and testbench

Parametrised 3x3 RGB565 stream filter. It combines a three-line window buffer and per-channel convolution in one block. It sits between the camera pixel stream and the frame-buffer/threshold stages. Compared with the earlier fixed filter, it adds:
- frame geometry parameters;
- a runtime kernel select, latched per frame;
- edge replication;
- a post-reset arming rule.

---
 rtl/filter_stream.sv | 241 ++++++++++++++++++++++++
 tb/tb_filter_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_stream.sv
// filter_stream: 3x3 RGB565 stream filter built from a line-memory ring, a 3x3 window
// and a per-channel convolution. The latency from an accepted input to its output is fixed at 4 cycles.
// Ports:
//   clk_in, rst_in - pixel clock and synchronous active-high reset
//   data_valid_in, pixel_data_in, hcount_in, vcount_in, kernel_sel_in - input stream
//   data_valid_out, pixel_data_out, hcount_out, vcount_out - filtered stream (centre coords)
module filter_stream #(
   parameter int         H_ACTIVE  = 320,
   parameter int         V_ACTIVE  = 180,
   parameter logic [1:0] K_DEFAULT = 2'd0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        data_valid_in,
   input  logic [15:0] pixel_data_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic [1:0]  kernel_sel_in,
   output logic        data_valid_out,
   output logic [15:0] pixel_data_out,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out
);

   localparam int AW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

   logic [15:0] r_lines [0:2][0:H_ACTIVE-1];

   logic          w_acc;
   logic          w_sof;
   logic [AW-1:0] w_hidx;
   logic [1:0]    w_wptr;
   logic [1:0]    w_rp1;
   logic [1:0]    w_rp2;

   logic       r_armed;
   logic [1:0] r_kernel;
   logic [1:0] r_ptr;

   logic        r1_acc;
   logic        r1_emit;
   logic [15:0] r1_top;
   logic [15:0] r1_mid;
   logic [15:0] r1_bot;
   logic [10:0] r1_h;
   logic [9:0]  r1_v;
   logic [1:0]  r1_k;

   logic                   r2_emit;
   logic [2:0][2:0][15:0]  r_win;
   logic [10:0]            r2_h;
   logic [9:0]             r2_v;
   logic [1:0]             r2_k;

   logic                r3_emit;
   logic signed [11:0]  r3_r;
   logic signed [11:0]  r3_g;
   logic signed [11:0]  r3_b;
   logic [10:0]         r3_h;
   logic [9:0]          r3_v;
   logic [1:0]          r3_k;

   logic [8:0][5:0] w_tr;
   logic [8:0][5:0] w_tg;
   logic [8:0][5:0] w_tb;
   logic            w_sh;

   // Row-major kernel taps, index 4 is the centre.
   function automatic logic signed [4:0] f_coef(input logic [1:0] k, input int i);
      logic signed [4:0] v;
      v = '0;
      case (k)
         2'd0:    v = (i == 4) ? 5'sd1 : 5'sd0;
         2'd1:    v = (i == 4) ? 5'sd4 : ((i % 2) == 1) ? 5'sd2 : 5'sd1;
         2'd2:    v = (i == 4) ? 5'sd5 : ((i % 2) == 1) ? -5'sd1 : 5'sd0;
         default: v = (i == 4) ? 5'sd8 : -5'sd1;
      endcase
      return v;
   endfunction

   function automatic logic signed [11:0] f_conv(input logic [8:0][5:0] t, input logic [1:0] k);
      logic signed [11:0] acc;
      logic signed [11:0] c;
      logic signed [11:0] x;
      logic signed [4:0]  cf;
      acc = '0;
      for (int i = 0; i < 9; i++) begin
         cf  = f_coef(k, i);
         c   = {{7{cf[4]}}, cf};
         x   = $signed({6'd0, t[i]});
         acc = acc + c * x;
      end
      return acc;
   endfunction

   function automatic logic [5:0] f_sat(input logic signed [11:0] a, input logic sh,
                                        input logic [5:0] mx);
      logic signed [11:0] s;
      s = sh ? (a >>> 4) : a;
      if (s < 12'sd0) return 6'd0;
      if (s > $signed({6'd0, mx})) return mx;
      return s[5:0];
   endfunction

   assign w_acc  = data_valid_in && (hcount_in < 11'(H_ACTIVE)) && (vcount_in < 10'(V_ACTIVE));
   assign w_sof  = w_acc && (hcount_in == '0) && (vcount_in == '0);
   assign w_hidx = hcount_in[AW-1:0];

   // Write slot of the current row; the other two slots hold rows v-1 and v-2.
   always_comb begin
      w_wptr = r_ptr;
      if (w_acc && (hcount_in == '0)) begin
         if (vcount_in == '0) w_wptr = 2'd0;
         else                 w_wptr = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
      end
      w_rp1 = (w_wptr == 2'd0) ? 2'd2 : w_wptr - 2'd1;
      w_rp2 = (w_wptr == 2'd2) ? 2'd0 : w_wptr + 2'd1;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && w_acc) r_lines[w_wptr][w_hidx] <= pixel_data_in;
   end

   // c1: line-memory read, arming and kernel latch
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_armed  <= 1'b0;
         r_kernel <= K_DEFAULT;
         r_ptr    <= 2'd0;
         r1_acc   <= 1'b0;
         r1_emit  <= 1'b0;
         r1_top   <= '0;
         r1_mid   <= '0;
         r1_bot   <= '0;
         r1_h     <= '0;
         r1_v     <= '0;
         r1_k     <= K_DEFAULT;
      end else begin
         r1_acc  <= w_acc;
         r1_emit <= w_acc && r_armed && (hcount_in != '0) && (vcount_in != '0);
         if (w_acc) begin
            r_ptr  <= w_wptr;
            r1_bot <= pixel_data_in;
            r1_mid <= r_lines[w_rp1][w_hidx];
            // On row 1 the row above the centre is row 0 itself.
            r1_top <= (vcount_in == 10'd1) ? r_lines[w_rp1][w_hidx]
                                          : r_lines[w_rp2][w_hidx];
            r1_h   <= hcount_in;
            r1_v   <= vcount_in;
            r1_k   <= w_sof ? kernel_sel_in : r_kernel;
         end
         if (w_sof) begin
            r_armed  <= 1'b1;
            r_kernel <= kernel_sel_in;
         end
      end
   end

   // c2: window shift; column 1 replicates column 0 into the left taps
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r2_emit <= 1'b0;
         r_win   <= '0;
         r2_h    <= '0;
         r2_v    <= '0;
         r2_k    <= K_DEFAULT;
      end else begin
         r2_emit <= r1_emit;
         if (r1_acc) begin
            for (int r = 0; r < 3; r++) begin
               r_win[r][0] <= (r1_h == 11'd1) ? r_win[r][2] : r_win[r][1];
               r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= r1_top;
            r_win[1][2] <= r1_mid;
            r_win[2][2] <= r1_bot;
            r2_h <= r1_h;
            r2_v <= r1_v;
            r2_k <= r1_k;
         end
      end
   end

   always_comb begin
      w_tr = '0;
      w_tg = '0;
      w_tb = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            w_tr[r*3+c] = {1'b0, r_win[r][c][15:11]};
            w_tg[r*3+c] = r_win[r][c][10:5];
            w_tb[r*3+c] = {1'b0, r_win[r][c][4:0]};
         end
      end
   end

   // c3: products and sums
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r3_emit <= 1'b0;
         r3_r    <= '0;
         r3_g    <= '0;
         r3_b    <= '0;
         r3_h    <= '0;
         r3_v    <= '0;
         r3_k    <= K_DEFAULT;
      end else begin
         r3_emit <= r2_emit;
         if (r2_emit) begin
            r3_r <= f_conv(w_tr, r2_k);
            r3_g <= f_conv(w_tg, r2_k);
            r3_b <= f_conv(w_tb, r2_k);
            r3_h <= r2_h;
            r3_v <= r2_v;
            r3_k <= r2_k;
         end
      end
   end

   assign w_sh = (r3_k == 2'd1);

   // c4: shift, clamp, output register
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         data_valid_out <= 1'b0;
         pixel_data_out <= '0;
         hcount_out     <= '0;
         vcount_out     <= '0;
      end else begin
         data_valid_out <= r3_emit;
         if (r3_emit) begin
            pixel_data_out <= {5'(f_sat(r3_r, w_sh, 6'd31)),
                               f_sat(r3_g, w_sh, 6'd63),
                               5'(f_sat(r3_b, w_sh, 6'd31))};
            hcount_out <= r3_h - 11'd1;
            vcount_out <= r3_v - 10'd1;
         end
      end
   end

endmodule

// File: tb/tb_filter_stream.sv
// tb_filter_stream: directed frames on an 8x4 geometry, image-level reference model,
// per-cycle output compare plus literal pins on selected results.
module tb_filter_stream;

   localparam int HA = 8;
   localparam int VA = 4;
   localparam int KC [4][9] = '{
      '{ 0,  0,  0,  0, 1,  0,  0,  0,  0},
      '{ 1,  2,  1,  2, 4,  2,  1,  2,  1},
      '{ 0, -1,  0, -1, 5, -1,  0, -1,  0},
      '{-1, -1, -1, -1, 8, -1, -1, -1, -1}
   };

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        data_valid_in;
   logic [15:0] pixel_data_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [1:0]  kernel_sel_in;
   logic        data_valid_out;
   logic [15:0] pixel_data_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;

   filter_stream #(
      .H_ACTIVE (HA),
      .V_ACTIVE (VA),
      .K_DEFAULT(2'd0)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .data_valid_in (data_valid_in),
      .pixel_data_in (pixel_data_in),
      .hcount_in     (hcount_in),
      .vcount_in     (vcount_in),
      .kernel_sel_in (kernel_sel_in),
      .data_valid_out(data_valid_out),
      .pixel_data_out(pixel_data_out),
      .hcount_out    (hcount_out),
      .vcount_out    (vcount_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int          due;
      int          fid;
      int          h;
      int          v;
      logic [15:0] pix;
   } exp_t;

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic rst_q    = 1'b0;

   exp_t        q[$];
   exp_t        e;
   logic [15:0] img [VA][HA];
   logic [15:0] cap [16][VA][HA];
   int          pcount [16];
   bit          m_armed = 1'b0;
   int          m_k     = 0;
   int          m_fid   = -1;
   int          cur_ks  = 0;

   always @(posedge clk_in) cyc   <= cyc + 1;
   always @(posedge clk_in) rst_q <= rst_in;

   function automatic int sat(int s, int mx);
      if (s < 0)  return 0;
      if (s > mx) return mx;
      return s;
   endfunction

   // Reference: 3x3 convolution on the frame image, edges clamped to row/col 0.
   function automatic logic [15:0] model_px(int ch, int cv, int k);
      int sr, sg, sb, x, y, c;
      logic [15:0] p;
      sr = 0; sg = 0; sb = 0;
      for (int dy = 0; dy < 3; dy++) begin
         for (int dx = 0; dx < 3; dx++) begin
            y = cv - 1 + dy;
            x = ch - 1 + dx;
            if (y < 0) y = 0;
            if (x < 0) x = 0;
            p = img[y][x];
            c = KC[k][dy*3+dx];
            sr += c * int'(p[15:11]);
            sg += c * int'(p[10:5]);
            sb += c * int'(p[4:0]);
         end
      end
      if (k == 1) begin
         sr = sr >>> 4;
         sg = sg >>> 4;
         sb = sb >>> 4;
      end
      return {5'(sat(sr, 31)), 6'(sat(sg, 63)), 5'(sat(sb, 31))};
   endfunction

   function automatic logic [15:0] pat(int mode, int h, int v);
      case (mode)
         0:       return 16'(h * 256 + v);
         1:       return 16'h7BEF;
         2:       return (h == 3 && v == 1) ? 16'hFFFF : 16'h0000;
         3:       return (h == 3 && v == 1) ? 16'h0000 : 16'hFFFF;
         default: return 16'((h * 37 + v * 101 + 7) * 613) ^ 16'h5A3C;
      endcase
   endfunction

   task automatic drive(bit dv, int h, int v, logic [15:0] px, bit rst);
      data_valid_in = dv;
      hcount_in     = 11'(h);
      vcount_in     = 10'(v);
      pixel_data_in = px;
      rst_in        = rst;
      kernel_sel_in = 2'(cur_ks);
      if (rst) begin
         while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
         m_armed = 1'b0;
         m_k     = 0;
      end else if (dv && h < HA && v < VA) begin
         img[v][h] = px;
         if (h == 0 && v == 0) begin
            m_armed = 1'b1;
            m_k     = cur_ks;
            m_fid++;
         end
         if (m_armed && h >= 1 && v >= 1)
            q.push_back('{cyc + 4, m_fid, h - 1, v - 1, model_px(h - 1, v - 1, m_k)});
      end
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b0, 0, 0, 16'hDEAD, 1'b0);
   endtask

   task automatic frame(int mode, int k0, int k1, int rh, int rv, bit gaps, bit drain);
      int n, r;
      cur_ks = k0;
      for (int v = 0; v < VA; v++) begin
         for (int h = 0; h < HA; h++) begin
            if (v == 1 && h == 0) cur_ks = k1;
            if (gaps) begin
               n = int'($urandom_range(2));
               repeat (n) begin
                  r = int'($urandom_range(2));
                  if (r == 0)      drive(1'b0, h, v, 16'hDEAD, 1'b0);
                  else if (r == 1) drive(1'b1, HA, v, 16'hFFFF, 1'b0);
                  else             drive(1'b1, h, VA, 16'hFFFF, 1'b0);
               end
            end
            drive(1'b1, h, v, pat(mode, h, v), (h == rh && v == rv));
         end
      end
      if (drain) idle(8);
   endtask

   task automatic lit(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   always @(negedge clk_in) begin
      if (rst_q) begin
         checks++;
         if (data_valid_out !== 1'b0 || pixel_data_out !== 16'h0 ||
             hcount_out !== 11'h0 || vcount_out !== 10'h0) begin
            failures++;
            $display("FAIL reset_out@%0d: valid=%b data=%h h=%0d v=%0d, required all 0",
                     cyc, data_valid_out, pixel_data_out, hcount_out, vcount_out);
         end
      end else if (q.size() > 0 && q[0].due == cyc) begin
         e = q.pop_front();
         checks++;
         if (data_valid_out !== 1'b1 || pixel_data_out !== e.pix ||
             hcount_out !== 11'(e.h) || vcount_out !== 10'(e.v)) begin
            failures++;
            $display("FAIL pulse@%0d: valid=%b data=%h h=%0d v=%0d, required 1 %h %0d %0d",
                     cyc, data_valid_out, pixel_data_out, hcount_out, vcount_out,
                     e.pix, e.h, e.v);
         end
         if (e.fid >= 0 && e.fid < 16) begin
            cap[e.fid][e.v][e.h] = pixel_data_out;
            pcount[e.fid]++;
         end
      end else begin
         checks++;
         if (data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL idle@%0d: valid=%b, required 0", cyc, data_valid_out);
         end
      end
   end

   initial begin
      for (int f = 0; f < 16; f++) begin
         pcount[f] = 0;
         for (int v = 0; v < VA; v++)
            for (int h = 0; h < HA; h++) cap[f][v][h] = 16'hDEAD;
      end
      rst_in        = 1'b1;
      data_valid_in = 1'b0;
      pixel_data_in = '0;
      hcount_in     = '0;
      vcount_in     = '0;
      kernel_sel_in = '0;
      @(posedge clk_in);
      #1;
      repeat (3) drive(1'b0, 0, 0, 16'h0, 1'b1);
      idle(2);
      // Not yet armed: a row without a preceding (0,0) yields nothing.
      for (int h = 0; h < HA; h++) drive(1'b1, h, 1, pat(4, h, 1), 1'b0);
      idle(6);
      frame(0, 0, 0, -1, -1, 1'b0, 1'b1);
      frame(1, 0, 0, -1, -1, 1'b0, 1'b1);
      frame(1, 1, 1, -1, -1, 1'b0, 1'b1);
      frame(1, 2, 2, -1, -1, 1'b0, 1'b1);
      frame(1, 3, 3, -1, -1, 1'b0, 1'b1);
      frame(2, 2, 2, -1, -1, 1'b0, 1'b1);
      frame(3, 2, 2, -1, -1, 1'b0, 1'b1);
      frame(1, 0, 3, -1, -1, 1'b0, 1'b0);
      frame(1, 3, 3, -1, -1, 1'b0, 1'b1);
      frame(0, 0, 0, 5, 2, 1'b0, 1'b1);
      frame(0, 0, 0, -1, -1, 1'b0, 1'b1);
      frame(4, 2, 2, -1, -1, 1'b0, 1'b1);
      frame(4, 1, 1, -1, -1, 1'b1, 1'b1);
      idle(4);

      lit("ident_count",   32'(pcount[0]),       32'd21);
      lit("ident_0_0",     32'(cap[0][0][0]),    32'h0000);
      lit("ident_6_2",     32'(cap[0][2][6]),    32'h0602);
      lit("flat_k0",       32'(cap[1][0][0]),    32'h7BEF);
      lit("flat_k1",       32'(cap[2][0][0]),    32'h7BEF);
      lit("flat_k2",       32'(cap[3][2][6]),    32'h7BEF);
      lit("flat_k3_edge",  32'(cap[4][0][0]),    32'h0000);
      lit("flat_k3_in",    32'(cap[4][2][6]),    32'h0000);
      lit("sat_hi",        32'(cap[5][1][3]),    32'hFFFF);
      lit("sat_lo",        32'(cap[6][1][3]),    32'h0000);
      lit("latch_ident",   32'(cap[7][2][6]),    32'h7BEF);
      lit("latch_ridge",   32'(cap[8][0][0]),    32'h0000);
      lit("rst_count",     32'(pcount[9]),       32'd8);
      lit("post_rst_cnt",  32'(pcount[10]),      32'd21);
      lit("post_rst_1_1",  32'(cap[10][1][1]),   32'h0101);
      lit("gaps_count",    32'(pcount[12]),      32'd21);
      lit("queue_empty",   32'(q.size()),        32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
